// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 scan-code constants, decoder state type and the scan-code to ASCII table.
package ps2_pkg;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  typedef enum logic [1:0] {DEC_BASE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;
  function automatic logic [7:0] scan2ascii(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    case (code)
      8'h1C: a = "a";
      8'h32: a = "b";
      8'h21: a = "c";
      8'h23: a = "d";
      8'h24: a = "e";
      8'h2B: a = "f";
      8'h34: a = "g";
      8'h33: a = "h";
      8'h43: a = "i";
      8'h3B: a = "j";
      8'h42: a = "k";
      8'h4B: a = "l";
      8'h3A: a = "m";
      8'h31: a = "n";
      8'h44: a = "o";
      8'h4D: a = "p";
      8'h15: a = "q";
      8'h2D: a = "r";
      8'h1B: a = "s";
      8'h2C: a = "t";
      8'h3C: a = "u";
      8'h2A: a = "v";
      8'h1D: a = "w";
      8'h22: a = "x";
      8'h35: a = "y";
      8'h1A: a = "z";
      8'h45: a = "0";
      8'h16: a = "1";
      8'h1E: a = "2";
      8'h26: a = "3";
      8'h25: a = "4";
      8'h2E: a = "5";
      8'h36: a = "6";
      8'h3D: a = "7";
      8'h3E: a = "8";
      8'h46: a = "9";
      SC_SPACE: a = 8'h20;
      SC_ENTER: a = 8'h0D;
      SC_BKSP:  a = 8'h08;
      default:  a = 8'h00;
    endcase
    return (upper && a >= "a" && a <= "z") ? a - 8'h20 : a;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronised, glitch-filtered PS/2 frame receiver with mid-frame timeout.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_DONE} rx_state_t;
  rx_state_t state, state_n;
  logic [1:0] c_sync, d_sync;
  logic [FILTER_LEN-1:0] c_sh, d_sh;
  logic c_f, d_f, c_q, fall, ok;
  logic [3:0] cnt, cnt_n;
  logic [9:0] sr, sr_n;
  logic [TW-1:0] tmr, tmr_n;
  // Lines idle high, so filters start high to avoid a spurious edge out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_sh <= '1;
      d_sh <= '1;
      c_f <= 1'b1;
      d_f <= 1'b1;
      c_q <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      c_sh <= {c_sh[FILTER_LEN-2:0], c_sync[1]};
      d_sh <= {d_sh[FILTER_LEN-2:0], d_sync[1]};
      c_f <= &c_sh ? 1'b1 : ~|c_sh ? 1'b0 : c_f;
      d_f <= &d_sh ? 1'b1 : ~|d_sh ? 1'b0 : d_f;
      c_q <= c_f;
    end
  assign fall = c_q & ~c_f;
  assign ok = sr[9] & (^sr[8:0]);
  assign rx_byte = sr[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RX_IDLE;
      cnt <= '0;
      sr <= '0;
      tmr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      tmr <= tmr_n;
    end
  // sr collects data, parity, stop with the stop bit ending up in sr[9]
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    tmr_n = tmr;
    rx_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      RX_IDLE:
        if (fall && !d_f) begin
          state_n = RX_DATA;
          cnt_n = '0;
          tmr_n = '0;
        end
      RX_DATA:
        if (fall) begin
          sr_n = {d_f, sr[9:1]};
          cnt_n = cnt + 4'd1;
          tmr_n = '0;
          state_n = cnt == 4'd9 ? RX_DONE : RX_DATA;
        end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = RX_IDLE;
          frame_err = 1'b1;
        end else
          tmr_n = tmr + TW'(1);
      default: begin
        state_n = RX_IDLE;
        rx_valid = ok;
        frame_err = ~ok;
      end
    endcase
  end
endmodule

// File: rtl/ps2_kbd_fifo_ctrl.sv
// ps2_kbd_fifo_ctrl: PS/2 keyboard decoder with Shift/CapsLock tracking and a buffered ASCII FIFO for the CPU.
module ps2_kbd_fifo_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        ps2c,
  input  logic                        ps2d,
  input  logic                        DoRead,
  output logic [7:0]                  ascii_code,
  output logic [$clog2(FIFO_DEPTH):0] key_count,
  output logic                        interrupt,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        caps_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic rx_valid;
  logic [7:0] rx_byte;
  dec_state_t dec, dec_n;
  logic shift_l, shift_r, shift_l_n, shift_r_n, caps_n, push_n, push_q, rd_ok, wr_ok;
  logic [7:0] asc_n, push_data;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt_n;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .rst(Reset), .ps2c(ps2c), .ps2d(ps2d),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );
  always_comb begin
    dec_n = dec;
    shift_l_n = shift_l;
    shift_r_n = shift_r;
    caps_n = caps_state;
    push_n = 1'b0;
    asc_n = scan2ascii(rx_byte, (shift_l | shift_r) ^ caps_state);
    if (rx_valid)
      case (dec)
        DEC_BASE: begin
          dec_n = rx_byte == SC_E0 ? DEC_E0 : rx_byte == SC_F0 ? DEC_F0 : DEC_BASE;
          if (rx_byte == SC_LSHIFT) shift_l_n = 1'b1;
          else if (rx_byte == SC_RSHIFT) shift_r_n = 1'b1;
          else if (rx_byte == SC_CAPS) caps_n = ~caps_state;
          else push_n = |asc_n;
        end
        DEC_E0: dec_n = rx_byte == SC_F0 ? DEC_E0F0 : DEC_BASE;
        DEC_F0: begin
          dec_n = DEC_BASE;
          shift_l_n = rx_byte == SC_LSHIFT ? 1'b0 : shift_l;
          shift_r_n = rx_byte == SC_RSHIFT ? 1'b0 : shift_r;
        end
        default: dec_n = DEC_BASE;
      endcase
  end
  // A pop on a full FIFO frees the slot the coincident push needs
  assign rd_ok = DoRead && |key_count;
  assign wr_ok = push_q && (key_count != (AW+1)'(FIFO_DEPTH) || rd_ok);
  assign cnt_n = key_count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      dec <= DEC_BASE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      caps_state <= 1'b0;
      push_q <= 1'b0;
      push_data <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      key_count <= '0;
      interrupt <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dec <= dec_n;
      shift_l <= shift_l_n;
      shift_r <= shift_r_n;
      caps_state <= caps_n;
      push_q <= push_n;
      push_data <= asc_n;
      rd_ptr <= rd_ptr + AW'(rd_ok);
      wr_ptr <= wr_ptr + AW'(wr_ok);
      key_count <= cnt_n;
      interrupt <= |cnt_n;
      overflow <= (push_q && !wr_ok) ? 1'b1 : rd_ok ? 1'b0 : overflow;
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= push_data;
  assign ascii_code = |key_count ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_ps2_kbd_fifo_ctrl.sv
// tb_ps2_kbd_fifo_ctrl: directed scenarios plus randomized scan streams against a queue-based keyboard model.
module tb_ps2_kbd_fifo_ctrl;
  localparam int DEPTH = 4, FLEN = 4, TMO = 200, H = 16;
  logic clk = 0, Reset = 1, ps2c = 1, ps2d = 1, DoRead = 0;
  logic [7:0] ascii_code;
  logic [$clog2(DEPTH):0] key_count;
  logic interrupt, overflow, frame_err, caps_state;
  int total = 0, bad = 0, ferr = 0;
  logic [7:0] let_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                              8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dig_sc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pool [24] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h15,8'h1A,8'h4D,8'h44,8'h45,8'h16,
                            8'h1E,8'h29,8'h5A,8'h66,8'h58,8'h58,8'hF0,8'hF0,8'hF0,8'hE0,8'h05,8'h76};
  logic [7:0] mq [$];
  bit m_e0, m_f0, m_sl, m_sr, m_caps, m_ov;

  ps2_kbd_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .Reset(Reset), .ps2c(ps2c), .ps2d(ps2d), .DoRead(DoRead),
    .ascii_code(ascii_code), .key_count(key_count), .interrupt(interrupt),
    .overflow(overflow), .frame_err(frame_err), .caps_state(caps_state)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) ferr++;

  function automatic logic [7:0] m_ascii(input logic [7:0] b, input bit up);
    for (int i = 0; i < 26; i++) if (let_sc[i] == b) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++) if (dig_sc[i] == b) return 8'h30 + 8'(i);
    return b == 8'h29 ? 8'h20 : b == 8'h5A ? 8'h0D : b == 8'h66 ? 8'h08 : 8'h00;
  endfunction

  task automatic m_byte(input logic [7:0] b);
    logic [7:0] a;
    if (b == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
    else if (b == 8'hF0 && !m_f0) m_f0 = 1;
    else begin
      if (!m_e0 && m_f0) begin
        if (b == 8'h12) m_sl = 0;
        if (b == 8'h59) m_sr = 0;
      end else if (!m_e0) begin
        if (b == 8'h12) m_sl = 1;
        else if (b == 8'h59) m_sr = 1;
        else if (b == 8'h58) m_caps = !m_caps;
        else begin
          a = m_ascii(b, (m_sl || m_sr) != m_caps);
          if (a != 0) begin
            if (mq.size() < DEPTH) mq.push_back(a);
            else m_ov = 1;
          end
        end
      end
      m_e0 = 0;
      m_f0 = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    repeat (H/2) @(negedge clk);
    ps2c = 0;
    repeat (H) @(negedge clk);
    ps2c = 1;
    repeat (H/2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(1'b1);
    ps2d = 1;
  endtask

  task automatic do_read();
    @(negedge clk) DoRead = 1;
    @(negedge clk) DoRead = 0;
  endtask

  task automatic apply_reset();
    Reset = 1;
    repeat (3) @(negedge clk);
    Reset = 0;
    @(negedge clk);
  endtask

  task automatic wait_rx(output bit seen);
    int i = 0;
    while (!dut.rx_valid && i < 2000) begin @(negedge clk); i++; end
    seen = dut.rx_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (key_count !== 0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", key_count); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("FAIL rst_ascii: got %h want 00", ascii_code); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", interrupt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL rst_caps: got %b want 0", caps_state); end
    do_read();
    total++; if (key_count !== 0) begin bad++; $display("FAIL empty_read_cnt: got %0d want 0", key_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL empty_read_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_make_break();
    bit seen;
    fork
      send_frame(8'h1C, 0);
      begin
        wait_rx(seen);
        total++; if (!seen) begin bad++; $display("FAIL mb_rx_valid: got none want pulse"); end
        @(negedge clk);
        total++; if (key_count !== 0) begin bad++; $display("FAIL mb_lat1_cnt: got %0d want 0", key_count); end
        @(negedge clk);
        total++; if (key_count !== 1) begin bad++; $display("FAIL mb_lat2_cnt: got %0d want 1", key_count); end
        total++; if (ascii_code !== 8'h61) begin bad++; $display("FAIL mb_lat2_ascii: got %h want 61", ascii_code); end
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL mb_lat2_irq: got %b want 1", interrupt); end
      end
    join
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    total++; if (key_count !== 1) begin bad++; $display("FAIL mb_break_cnt: got %0d want 1", key_count); end
    do_read();
    total++; if (ascii_code !== 8'h00) begin bad++; $display("FAIL mb_read_ascii: got %h want 00", ascii_code); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL mb_read_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_shift_caps();
    logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [7:0] cseq [4] = '{8'h58, 8'hF0, 8'h58, 8'h1C};
    foreach (seq[i]) send_frame(seq[i], 0);
    total++; if (key_count !== 2) begin bad++; $display("FAIL sh_cnt: got %0d want 2", key_count); end
    total++; if (ascii_code !== 8'h41) begin bad++; $display("FAIL sh_head0: got %h want 41", ascii_code); end
    do_read();
    total++; if (ascii_code !== 8'h61) begin bad++; $display("FAIL sh_head1: got %h want 61", ascii_code); end
    do_read();
    foreach (cseq[i]) send_frame(cseq[i], 0);
    total++; if (caps_state !== 1'b1) begin bad++; $display("FAIL caps_state: got %b want 1", caps_state); end
    total++; if (ascii_code !== 8'h41) begin bad++; $display("FAIL caps_ascii: got %h want 41", ascii_code); end
    total++; if (key_count !== 1) begin bad++; $display("FAIL caps_cnt: got %0d want 1", key_count); end
    do_read();
  endtask

  task automatic test_parity();
    int f0 = ferr;
    send_frame(8'h16, 1);
    total++; if (ferr - f0 !== 1) begin bad++; $display("FAIL par_ferr: got %0d pulses want 1", ferr - f0); end
    total++; if (key_count !== 0) begin bad++; $display("FAIL par_cnt: got %0d want 0", key_count); end
    send_frame(8'h45, 0);
    total++; if (ascii_code !== 8'h30) begin bad++; $display("FAIL par_next_ascii: got %h want 30", ascii_code); end
    total++; if (ferr - f0 !== 1) begin bad++; $display("FAIL par_next_ferr: got %0d pulses want 1", ferr - f0); end
    do_read();
  endtask

  task automatic test_overflow();
    bit seen;
    repeat (DEPTH + 1) send_frame(8'h29, 0);
    total++; if (key_count !== DEPTH) begin bad++; $display("FAIL ov_cnt: got %0d want %0d", key_count, DEPTH); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_set: got %b want 1", overflow); end
    total++; if (ascii_code !== 8'h20) begin bad++; $display("FAIL ov_ascii: got %h want 20", ascii_code); end
    do_read();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_clr: got %b want 0", overflow); end
    total++; if (key_count !== DEPTH - 1) begin bad++; $display("FAIL ov_rd_cnt: got %0d want %0d", key_count, DEPTH - 1); end
    send_frame(8'h29, 0);
    total++; if (key_count !== DEPTH) begin bad++; $display("FAIL ov_refill: got %0d want %0d", key_count, DEPTH); end
    fork
      send_frame(8'h5A, 0);
      begin
        wait_rx(seen);
        total++; if (!seen) begin bad++; $display("FAIL ov_rx_valid: got none want pulse"); end
        @(negedge clk) DoRead = 1;
        @(negedge clk) DoRead = 0;
      end
    join
    total++; if (key_count !== DEPTH) begin bad++; $display("FAIL ov_simul_cnt: got %0d want %0d", key_count, DEPTH); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_simul_ovf: got %b want 0", overflow); end
    repeat (DEPTH - 1) do_read();
    total++; if (ascii_code !== 8'h0D) begin bad++; $display("FAIL ov_tail: got %h want 0d", ascii_code); end
    do_read();
    total++; if (key_count !== 0) begin bad++; $display("FAIL ov_drain: got %0d want 0", key_count); end
  endtask

  task automatic test_extended_timeout();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    int f0;
    foreach (seq[i]) send_frame(seq[i], 0);
    total++; if (key_count !== 0) begin bad++; $display("FAIL ext_cnt: got %0d want 0", key_count); end
    f0 = ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2d = 1;
    repeat (TMO + 50) @(negedge clk);
    total++; if (ferr - f0 !== 1) begin bad++; $display("FAIL tmo_ferr: got %0d pulses want 1", ferr - f0); end
    send_frame(8'h5A, 0);
    total++; if (ascii_code !== 8'h0D) begin bad++; $display("FAIL tmo_next_ascii: got %h want 0d", ascii_code); end
    total++; if (key_count !== 1) begin bad++; $display("FAIL tmo_next_cnt: got %0d want 1", key_count); end
    do_read();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h1C;
    repeat (3) send_frame(8'h29, 0);
    total++; if (key_count !== 3) begin bad++; $display("FAIL rm_pre_cnt: got %0d want 3", key_count); end
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    ps2d = b[4];
    repeat (H/2) @(negedge clk);
    ps2c = 0;
    repeat (H/2) @(negedge clk);
    Reset = 1;
    #1;
    total++; if (key_count !== 0) begin bad++; $display("FAIL rm_cnt: got %0d want 0", key_count); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("FAIL rm_ascii: got %h want 00", ascii_code); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rm_irq: got %b want 0", interrupt); end
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL rm_caps: got %b want 0", caps_state); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rm_ovf: got %b want 0", overflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rm_ferr: got %b want 0", frame_err); end
    ps2c = 1;
    ps2d = 1;
    repeat (4) @(negedge clk);
    Reset = 0;
    repeat (H) @(negedge clk);
    send_frame(8'h1C, 0);
    total++; if (key_count !== 1) begin bad++; $display("FAIL rm_next_cnt: got %0d want 1", key_count); end
    total++; if (ascii_code !== 8'h61) begin bad++; $display("FAIL rm_next_ascii: got %h want 61", ascii_code); end
  endtask

  task automatic test_random();
    logic [7:0] b, exp;
    apply_reset();
    mq.delete();
    {m_e0, m_f0, m_sl, m_sr, m_caps, m_ov} = '0;
    for (int n = 0; n < 60; n++) begin
      b = pool[$urandom_range(0, 23)];
      send_frame(b, 0);
      m_byte(b);
      exp = mq.size() > 0 ? mq[0] : 8'h00;
      total++; if (key_count !== mq.size()) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, key_count, mq.size()); end
      total++; if (ascii_code !== exp) begin bad++; $display("FAIL rnd_ascii[%0d]: got %h want %h", n, ascii_code, exp); end
      total++; if (interrupt !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, interrupt, mq.size() > 0); end
      total++; if (overflow !== m_ov) begin bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, overflow, m_ov); end
      total++; if (caps_state !== m_caps) begin bad++; $display("FAIL rnd_caps[%0d]: got %b want %b", n, caps_state, m_caps); end
      if ($urandom_range(0, 2) == 0) begin
        do_read();
        if (mq.size() > 0) begin void'(mq.pop_front()); m_ov = 0; end
        exp = mq.size() > 0 ? mq[0] : 8'h00;
        total++; if (key_count !== mq.size()) begin bad++; $display("FAIL rnd_rd_cnt[%0d]: got %0d want %0d", n, key_count, mq.size()); end
        total++; if (ascii_code !== exp) begin bad++; $display("FAIL rnd_rd_ascii[%0d]: got %h want %h", n, ascii_code, exp); end
        total++; if (overflow !== m_ov) begin bad++; $display("FAIL rnd_rd_ovf[%0d]: got %b want %b", n, overflow, m_ov); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift_caps();
    test_parity();
    test_overflow();
    test_extended_timeout();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
